fir_comp_deci: RTL and testbench

FIR_COMP_DECI -- requirements
Module: fir_comp_deci

---
 rtl/fir_comp_deci.sv | 213 +++++++++++++++++++++
 tb/tb_fir_comp_deci.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_comp_deci.sv
// fir_comp_deci: 8-tap symmetric FIR CIC compensator, decimating by 2.
//
// Samples are accepted on cke strobes and shifted into an 8-deep delay
// line. Every second accepted sample starts a compute. The compute
// folds the symmetric taps pairwise: one pre-add and one multiply per
// cycle over four MAC cycles. The sum is then rounded, saturated or
// wrapped, and registered. Strobes that arrive while a compute is in
// flight are dropped, and they set a sticky overrun flag.
//
// Ports:
//   clk      sole clock, rising edge
//   rst      asynchronous active-high reset
//   cke      one-cycle input strobe qualifying din
//   din      signed input sample (width bits)
//   dout     signed filtered output, registered, held between updates
//   cke_out  one-cycle strobe, high while a new dout is first visible
//   ovf      sticky overrun flag, set when a strobe is dropped
module fir_comp_deci #(
    parameter int width  = 16,
    parameter bit sat_en = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cke,
    input  logic signed [width-1:0] din,
    output logic signed [width-1:0] dout,
    output logic                    cke_out,
    output logic                    ovf
);

    localparam int acc_w  = 36;
    localparam int pre_w  = width + 1;
    localparam int prod_w = 2 * width + 1;
    localparam int taps_n = 8;

    // Only the outer half of the symmetric coefficient set is stored.
    localparam logic signed [width-1:0] coef_0 = -16'sd1024;
    localparam logic signed [width-1:0] coef_1 =  16'sd0;
    localparam logic signed [width-1:0] coef_2 =  16'sd5120;
    localparam logic signed [width-1:0] coef_3 =  16'sd12288;

    localparam logic signed [acc_w-1:0] round_half = 36'sd16384;
    localparam logic signed [acc_w-1:0] out_max    = 36'sd32767;
    localparam logic signed [acc_w-1:0] out_min    = -36'sd32768;

    typedef enum logic [2:0] {
        IDLE,
        MAC0,
        MAC1,
        MAC2,
        MAC3,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [width-1:0] taps [taps_n];
    logic                    phase;
    logic signed [acc_w-1:0] acc;

    logic                    accept;
    logic                    start;
    logic                    in_mac;

    logic signed [width-1:0] pre_a;
    logic signed [width-1:0] pre_b;
    logic signed [width-1:0] coef;
    logic signed [pre_w-1:0] pre_sum;
    logic signed [prod_w-1:0] product;
    logic signed [acc_w-1:0] product_ext;

    logic signed [acc_w-1:0] rounded;
    logic signed [acc_w-1:0] shifted;
    logic signed [width-1:0] result;

    // A strobe is only taken while idle; anything arriving during
    // MAC0..OUT (including the OUT->IDLE cycle) is an overrun.
    assign accept = cke && (state == IDLE);
    assign start  = accept && phase;
    assign in_mac = (state == MAC0) || (state == MAC1) ||
                    (state == MAC2) || (state == MAC3);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a fixed walk through the four MAC cycles and
    // one output cycle once a compute has been started.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MAC0;
            MAC0:    state_next = MAC1;
            MAC1:    state_next = MAC2;
            MAC2:    state_next = MAC3;
            MAC3:    state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Tap pair and coefficient for the current MAC cycle: MACk folds
    // x[n-k] with its mirror x[n-7+k].
    always_comb begin
        pre_a = taps[0];
        pre_b = taps[7];
        coef  = coef_0;
        case (state)
            MAC1: begin
                pre_a = taps[1];
                pre_b = taps[6];
                coef  = coef_1;
            end
            MAC2: begin
                pre_a = taps[2];
                pre_b = taps[5];
                coef  = coef_2;
            end
            MAC3: begin
                pre_a = taps[3];
                pre_b = taps[4];
                coef  = coef_3;
            end
            default: begin
                pre_a = taps[0];
                pre_b = taps[7];
                coef  = coef_0;
            end
        endcase
    end

    // The pre-add needs one extra bit, so the full -32768..32767 pair
    // sum cannot overflow before the multiply.
    always_comb begin
        pre_sum     = {pre_a[width-1], pre_a} + {pre_b[width-1], pre_b};
        product     = pre_sum * coef;
        product_ext = {{(acc_w - prod_w){product[prod_w-1]}}, product};
    end

    // Round half up, then either clamp to the output range or keep the
    // low bits for two's-complement wrap.
    always_comb begin
        rounded = acc + round_half;
        shifted = rounded >>> 15;
        result  = shifted[width-1:0];
        if (sat_en) begin
            if (shifted > out_max) begin
                result = out_max[width-1:0];
            end else if (shifted < out_min) begin
                result = out_min[width-1:0];
            end
        end
    end

    // The delay line and phase bit only move on accepted samples, so the
    // taps stay frozen for the whole compute.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < taps_n; i++) begin
                taps[i] <= '0;
            end
            phase <= 1'b0;
        end else if (accept) begin
            for (int i = taps_n - 1; i > 0; i--) begin
                taps[i] <= taps[i-1];
            end
            taps[0] <= din;
            phase   <= ~phase;
        end
    end

    // The accumulator clears as the compute starts and sums one folded
    // product per MAC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (start) begin
            acc <= '0;
        end else if (in_mac) begin
            acc <= acc + product_ext;
        end
    end

    // The output register and strobe update together on the OUT cycle,
    // so dout only ever changes alongside cke_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout    <= '0;
            cke_out <= 1'b0;
        end else begin
            cke_out <= (state == OUT);
            if (state == OUT) begin
                dout <= result;
            end
        end
    end

    // Sticky overrun: any strobe seen while busy sets it until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (cke && (state != IDLE)) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_comp_deci.sv
// tb_fir_comp_deci: self-checking bench for fir_comp_deci.
//
// Two instances share the same stimulus: one saturating and one wrapping.
// A behavioural model runs the full 8-tap convolution on a history of
// accepted samples. It tracks the busy window after each compute start
// and checks cke_out, dout (both instances) and ovf every cycle.
// Directed table vectors and hand-written corner sequences add fixed
// expected values on top of that.
module tb_fir_comp_deci;

    logic               clk;
    logic               rst;
    logic               cke;
    logic signed [15:0] din;
    logic signed [15:0] dout_sat;
    logic signed [15:0] dout_wrap;
    logic               cke_out_sat;
    logic               cke_out_wrap;
    logic               ovf_sat;
    logic               ovf_wrap;

    fir_comp_deci #(.width(16), .sat_en(1'b1)) dut_sat (
        .clk     (clk),
        .rst     (rst),
        .cke     (cke),
        .din     (din),
        .dout    (dout_sat),
        .cke_out (cke_out_sat),
        .ovf     (ovf_sat)
    );

    fir_comp_deci #(.width(16), .sat_en(1'b0)) dut_wrap (
        .clk     (clk),
        .rst     (rst),
        .cke     (cke),
        .din     (din),
        .dout    (dout_wrap),
        .cke_out (cke_out_wrap),
        .ovf     (ovf_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state.
    int  hist [8];
    bit  m_phase;
    int  cyc;
    int  start_cyc;
    int  due_cyc;
    int  pend_sat;
    int  pend_wrap;
    int  m_dout_sat;
    int  m_dout_wrap;
    bit  m_ovf;
    bit  m_cko;

    typedef struct {
        bit                 rst_before;
        logic signed [15:0] din;
        bit                 chk;
        int                 exp_sat;
        int                 exp_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic check_output(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Full convolution of the 8 most recent accepted samples with the
    // compensator coefficients, rounded half up.
    function automatic int model_out(input bit sat);
        int   coefs [8] = '{-1024, 0, 5120, 12288, 12288, 5120, 0, -1024};
        longint sum = 0;
        longint r;
        int   w;
        for (int i = 0; i < 8; i++) begin
            sum += longint'(coefs[i]) * longint'(hist[i]);
        end
        r = (sum + 16384) >>> 15;
        if (sat) begin
            if (r > 32767)  r = 32767;
            if (r < -32768) r = -32768;
            return int'(r);
        end
        w = int'(r & 64'hffff);
        if (w >= 32768) w -= 65536;
        return w;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) hist[i] = 0;
        m_phase     = 1'b0;
        start_cyc   = cyc - 100;
        due_cyc     = -1;
        m_dout_sat  = 0;
        m_dout_wrap = 0;
        m_ovf       = 1'b0;
        m_cko       = 1'b0;
    endtask

    // One clock cycle: present inputs, let the model decide what the
    // strobe does, advance the clock and compare every output.
    task automatic apply_stimulus(input bit c, input logic signed [15:0] d);
        int age;
        cke = c;
        din = d;
        age = cyc - start_cyc;
        if (c) begin
            if (age >= 1 && age <= 5) begin
                m_ovf = 1'b1;
            end else begin
                for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = int'(d);
                if (m_phase) begin
                    start_cyc = cyc;
                    due_cyc   = cyc + 6;
                    pend_sat  = model_out(1'b1);
                    pend_wrap = model_out(1'b0);
                end
                m_phase = ~m_phase;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        cke = 1'b0;
        din = '0;
        m_cko = (cyc == due_cyc);
        if (m_cko) begin
            m_dout_sat  = pend_sat;
            m_dout_wrap = pend_wrap;
        end
        check_output("cke_out_sat",  int'(cke_out_sat),  int'(m_cko));
        check_output("cke_out_wrap", int'(cke_out_wrap), int'(m_cko));
        check_output("dout_sat",     int'(dout_sat),     m_dout_sat);
        check_output("dout_wrap",    int'(dout_wrap),    m_dout_wrap);
        check_output("ovf",          int'(ovf_sat),      int'(m_ovf));
    endtask

    // One accepted-or-dropped sample followed by the nominal 8-clock gap.
    task automatic send_sample(input logic signed [15:0] d);
        apply_stimulus(1'b1, d);
        repeat (7) apply_stimulus(1'b0, '0);
    endtask

    // Asynchronous reset: outputs must clear before the next clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_output("rst_dout_sat",  int'(dout_sat),    0);
        check_output("rst_dout_wrap", int'(dout_wrap),   0);
        check_output("rst_cke_out",   int'(cke_out_sat), 0);
        check_output("rst_ovf",       int'(ovf_sat),     0);
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        model_clear();
    endtask

    function automatic void add_vec(input bit r, input logic signed [15:0] d,
                                    input bit chk, input int es, input int ew);
        vec_t v;
        v.rst_before = r;
        v.din        = d;
        v.chk        = chk;
        v.exp_sat    = es;
        v.exp_wrap   = ew;
        vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b1;
        cke = 1'b0;
        din = '0;
        cyc = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_output("por_dout",    int'(dout_sat),    0);
        check_output("por_cke_out", int'(cke_out_sat), 0);
        check_output("por_ovf",     int'(ovf_sat),     0);
        rst = 1'b0;

        // DC: unity gain once all 8 taps hold the level.
        add_vec(1'b1, 16'sd1000, 1'b0, 0, 0);
        for (int i = 1; i < 7; i++) add_vec(1'b0, 16'sd1000, 1'b0, 0, 0);
        add_vec(1'b0, 16'sd1000, 1'b1, 1000, 1000);
        // Impulse: outputs walk through c1, c3, c5, c7 scaled by 1/2.
        add_vec(1'b1, 16'sd16384, 1'b0, 0, 0);
        add_vec(1'b0, 16'sd0, 1'b1, 0, 0);
        add_vec(1'b0, 16'sd0, 1'b0, 0, 0);
        add_vec(1'b0, 16'sd0, 1'b1, 6144, 6144);
        add_vec(1'b0, 16'sd0, 1'b0, 0, 0);
        add_vec(1'b0, 16'sd0, 1'b1, 2560, 2560);
        add_vec(1'b0, 16'sd0, 1'b0, 0, 0);
        add_vec(1'b0, 16'sd0, 1'b1, -512, -512);
        add_vec(1'b0, 16'sd0, 1'b0, 0, 0);
        add_vec(1'b0, 16'sd0, 1'b1, 0, 0);
        // Saturation: sum = 65536*1024 + 65534*(5120+12288) = 1207924736,
        // rounded >>15 = 36863, which clamps to 32767 or wraps to -28673.
        add_vec(1'b1, -16'sd32768, 1'b0, 0, 0);
        add_vec(1'b0, 16'sd0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) add_vec(1'b0, 16'sd32767, 1'b0, 0, 0);
        add_vec(1'b0, 16'sd0, 1'b0, 0, 0);
        add_vec(1'b0, -16'sd32768, 1'b1, 32767, -28673);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            send_sample(vecs[i].din);
            if (vecs[i].chk) begin
                check_output("vec_sat",  int'(dout_sat),  vecs[i].exp_sat);
                check_output("vec_wrap", int'(dout_wrap), vecs[i].exp_wrap);
            end
        end
        check_output("vec_ovf_clear", int'(ovf_sat), 0);

        // Latency and overrun: start at t, extra strobe at t+3.
        do_reset();
        send_sample(16'sd500);
        apply_stimulus(1'b1, 16'sd700);
        apply_stimulus(1'b0, '0);
        apply_stimulus(1'b0, '0);
        apply_stimulus(1'b1, 16'sd9999);
        check_output("ovr_ovf_t4", int'(ovf_sat), 1);
        apply_stimulus(1'b0, '0);
        check_output("ovr_cko_t5", int'(cke_out_sat), 0);
        apply_stimulus(1'b0, '0);
        check_output("ovr_cko_t6", int'(cke_out_sat), 1);
        check_output("ovr_dout_t6", int'(dout_sat), -22);
        apply_stimulus(1'b0, '0);
        check_output("ovr_cko_t7", int'(cke_out_sat), 0);
        repeat (3) apply_stimulus(1'b0, '0);
        // The dropped 9999 must not have entered the delay line.
        send_sample(16'sd0);
        send_sample(16'sd0);
        check_output("ovr_history", int'(dout_sat), 297);
        check_output("ovr_ovf_held", int'(ovf_sat), 1);

        // Reset in the middle of a compute aborts it.
        send_sample(16'sd100);
        apply_stimulus(1'b1, 16'sd200);
        apply_stimulus(1'b1, 16'sd300);
        do_reset();
        repeat (10) apply_stimulus(1'b0, '0);
        send_sample(16'sd1000);
        send_sample(16'sd1000);
        check_output("rst_mid_sat",  int'(dout_sat),  -31);
        check_output("rst_mid_wrap", int'(dout_wrap), -31);

        // Random samples at legal spacing: no overrun may appear.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            int gap = $urandom_range(6, 12);
            apply_stimulus(1'b1, 16'($urandom));
            repeat (gap - 1) apply_stimulus(1'b0, '0);
        end
        check_output("rand_no_ovf", int'(ovf_sat), 0);

        // Random samples with tight spacing to exercise the drop window.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            int gap = $urandom_range(1, 10);
            apply_stimulus(1'b1, 16'($urandom));
            repeat (gap - 1) apply_stimulus(1'b0, '0);
        end
        repeat (8) apply_stimulus(1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
